// File: rtl/supermic_pkg.sv
// Shared constants and types for the beamformer back end.
package supermic_pkg;
  localparam int BEAM_W        = 22;
  localparam int ENERGY_W      = 2 * BEAM_W - 1;
  localparam int BEAM_ENERGY_W = 32;

  typedef logic [BEAM_ENERGY_W-1:0] beam_energy_t;
endpackage

// File: rtl/beam_square.sv
// One-register signed squarer with a valid passthrough and a synchronous flush.
module beam_square
  import supermic_pkg::*;
#(
  parameter int IN_W = BEAM_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_sum,
  output logic                   out_valid,
  output logic [2*IN_W-2:0]      out_sq
);
  localparam int SQ_W = 2 * IN_W - 1;

  // The largest square, (-2^(IN_W-1))^2, fits in SQ_W bits, so squaring
  // modulo 2^SQ_W yields the exact unsigned result.
  logic signed [SQ_W-1:0] ext;
  logic        [SQ_W-1:0] sq_next;

  assign ext     = {{(IN_W-1){in_sum[IN_W-1]}}, in_sum};
  assign sq_next = ext * ext;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sq    <= '0;
    end else begin
      out_valid <= in_valid && !clear;
      out_sq    <= sq_next;
    end
  end
endmodule

// File: rtl/beam_energy_accum.sv
// Windowed beam energy: square each sample, sum over 2^WIN_LOG2 samples,
// scale and saturate, then hold the result on a valid/ready output.
module beam_energy_accum
  import supermic_pkg::*;
#(
  parameter int IN_W     = BEAM_W,
  parameter int WIN_LOG2 = 10,
  parameter int SHIFT    = 21,
  parameter int OUT_W    = BEAM_ENERGY_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_sum,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_energy,
  output logic                   out_sat,
  output logic                   overrun
);
  localparam int SQ_W  = 2 * IN_W - 1;
  localparam int ACC_W = SQ_W + WIN_LOG2;

  // S1: input register
  logic                   s1_valid;
  logic signed [IN_W-1:0] s1_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= in_valid && !clear;
      s1_sum   <= in_sum;
    end
  end

  // S2: square
  logic            s2_valid;
  logic [SQ_W-1:0] s2_sq;

  beam_square #(.IN_W(IN_W)) u_square (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (s1_valid),
    .in_sum    (s1_sum),
    .out_valid (s2_valid),
    .out_sq    (s2_sq)
  );

  // S3: accumulator, sample counter and scaled/saturated window result
  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] cnt;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    shifted;
  logic                last;
  logic                sat_next;
  logic [OUT_W-1:0]    energy_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_sum  = acc + ACC_W'(s2_sq);
    last     = (cnt == '1);
    shifted  = acc_sum >> SHIFT;
    sat_next = 1'b0;
    for (int i = OUT_W; i < ACC_W; i++) begin
      if (shifted[i]) sat_next = 1'b1;
    end
    energy_next = sat_next ? '1 : OUT_W'(shifted);
  end

  logic             fin_valid;
  logic [OUT_W-1:0] fin_energy;
  logic             fin_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      fin_valid  <= 1'b0;
      fin_energy <= '0;
      fin_sat    <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      fin_valid <= 1'b0;
    end else begin
      fin_valid <= s2_valid && last;
      if (s2_valid) begin
        if (last) begin
          // The next window starts fresh with the next valid sample.
          acc        <= '0;
          cnt        <= '0;
          fin_energy <= energy_next;
          fin_sat    <= sat_next;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_energy <= '0;
      out_sat    <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else if (fin_valid) begin
      if (!out_valid || out_ready) begin
        out_valid  <= 1'b1;
        out_energy <= fin_energy;
        out_sat    <= fin_sat;
      end else begin
        // Consumer still holds the previous result: keep it, drop the new one.
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_beam_energy_accum.sv
// Directed bench for beam_energy_accum with a 4-sample window.
module tb_beam_energy_accum;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [21:0] in_sum;
  logic               clear;
  logic               out_ready;

  logic        out_valid, out_sat, overrun;
  logic [31:0] out_energy;
  logic        s4_valid, s4_sat, s4_overrun;
  logic [31:0] s4_energy;

  beam_energy_accum #(.IN_W(22), .WIN_LOG2(2), .SHIFT(0), .OUT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_energy (out_energy),
    .out_sat    (out_sat),
    .overrun    (overrun)
  );

  beam_energy_accum #(.IN_W(22), .WIN_LOG2(2), .SHIFT(4), .OUT_W(32)) dut_s4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .clear      (clear),
    .out_valid  (s4_valid),
    .out_ready  (out_ready),
    .out_energy (s4_energy),
    .out_sat    (s4_sat),
    .overrun    (s4_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 time unit after the rising edge, so the falling-edge
  // value of the handshake equals what the next rising edge sees.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_energy);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic signed [21:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    tick();
    in_valid = 1'b0;
    in_sum   = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_energy", out_energy, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(1);

    // Four samples of 1000: result appears exactly 3 edges after the last one
    repeat (4) send(22'sd1000);
    idle(2);
    check("lat_not_early", out_valid, 0);
    idle(1);
    check("lat_valid", out_valid, 1);
    check("w1000_energy", out_energy, 4000000);
    check("w1000_sat", out_sat, 0);
    accept();
    check("accept_drops_valid", out_valid, 0);

    // Full-scale negative samples saturate
    repeat (4) send(-22'sd2097152);
    idle(3);
    check("sat_valid", out_valid, 1);
    check("sat_energy", out_energy, 64'hFFFF_FFFF);
    check("sat_flag", out_sat, 1);
    accept();

    // Back-to-back windows with out_ready held high
    got_q.delete();
    got_cyc.delete();
    out_ready = 1'b1;
    send(22'sd1000);
    send(-22'sd1000);
    send(22'sd500);
    send(-22'sd500);
    repeat (4) send(22'sd3);
    idle(6);
    out_ready = 1'b0;
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_first", got_q[0], 2500000);
      check("b2b_second", got_q[1], 36);
      check("b2b_spacing", got_cyc[1] - got_cyc[0], 4);
    end
    check("b2b_no_overrun", overrun, 0);

    // Held result and sticky overrun, then clear
    repeat (4) send(22'sd1000);
    idle(4);
    check("hold_valid", out_valid, 1);
    check("hold_no_overrun_yet", overrun, 0);
    repeat (4) send(22'sd2);
    idle(4);
    check("hold_energy_stable", out_energy, 4000000);
    check("hold_still_valid", out_valid, 1);
    check("overrun_set", overrun, 1);
    pulse_clear();
    check("clear_out_valid", out_valid, 0);
    check("clear_overrun", overrun, 0);

    // Reset mid-window discards the partial window
    got_q.delete();
    out_ready = 1'b1;
    repeat (2) send(22'sd1000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) send(22'sd2);
    idle(5);
    out_ready = 1'b0;
    check("rst_mid_count", got_q.size(), 1);
    if (got_q.size() == 1) check("rst_mid_energy", got_q[0], 16);

    // SHIFT=4 instance: clear colliding with the 4th sample drops the window
    pulse_clear();
    repeat (3) send(22'sd100);
    in_valid = 1'b1;
    in_sum   = 22'sd100;
    clear    = 1'b1;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    idle(5);
    check("clr_drop_s4_valid", s4_valid, 0);
    check("clr_drop_valid", out_valid, 0);
    repeat (4) send(22'sd100);
    idle(4);
    check("s4_valid", s4_valid, 1);
    check("s4_energy", s4_energy, 2500);
    check("s4_sat", s4_sat, 0);
    check("s0_energy_100", out_energy, 40000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
